// File: rtl/pipe_stage_buf_pkg.sv
// Shared widths and skid-FSM state encoding for the pipeline-stage buffer.
package pipe_stage_buf_pkg;

  localparam int unsigned REG_WIDTH = 32;
  localparam int unsigned PC_WIDTH  = 32;

  localparam int unsigned DEF_CTRL_WIDTH = 8;
  // Two register operands plus the PC make up the default payload.
  localparam int unsigned DEF_DATA_WIDTH = 2 * REG_WIDTH + PC_WIDTH;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } skid_state_e;

endpackage

// File: rtl/pipe_stage_buf_slot.sv
// One held pipeline entry {valid, ctrl, data}; clear wins over load, bubble zeroes ctrl on load.
module pipe_slot
  import pipe_stage_buf_pkg::*;
#(
  parameter int unsigned CTRL_WIDTH = DEF_CTRL_WIDTH,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear_i,
  input  logic                  load_i,
  input  logic                  bubble_i,
  input  logic [CTRL_WIDTH-1:0] ctrl_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  valid_o,
  output logic [CTRL_WIDTH-1:0] ctrl_o,
  output logic [DATA_WIDTH-1:0] data_o
);

  logic                  valid_q;
  logic [CTRL_WIDTH-1:0] ctrl_q;
  logic [DATA_WIDTH-1:0] data_q;

  always_ff @(posedge clk) begin
    if (reset || clear_i) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      data_q  <= '0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      ctrl_q  <= bubble_i ? '0 : ctrl_i;
      data_q  <= data_i;
    end
  end

  assign valid_o = valid_q;
  assign ctrl_o  = ctrl_q;
  assign data_o  = data_q;

endmodule

// File: rtl/pipe_stage_buf.sv
// Pipeline-stage register with valid/ready handshake, bubble insertion, flush and optional skid entry.
module pipe_stage_buf
  import pipe_stage_buf_pkg::*;
#(
  parameter int unsigned CTRL_WIDTH = DEF_CTRL_WIDTH,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned SKID       = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_bubble,
  input  logic [CTRL_WIDTH-1:0] in_ctrl,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CTRL_WIDTH-1:0] out_ctrl,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [1:0]            occupancy
);

  logic                  accept;
  logic                  emit;
  logic                  head_valid;
  logic [CTRL_WIDTH-1:0] head_ctrl;
  logic [DATA_WIDTH-1:0] head_data;
  logic                  head_load;
  logic                  head_clear;
  logic                  head_bubble;
  logic [CTRL_WIDTH-1:0] head_ctrl_in;
  logic [DATA_WIDTH-1:0] head_data_in;

  assign accept = in_valid & in_ready;
  assign emit   = head_valid & out_ready;

  pipe_slot #(
    .CTRL_WIDTH (CTRL_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_head (
    .clk      (clk),
    .reset    (reset),
    .clear_i  (head_clear),
    .load_i   (head_load),
    .bubble_i (head_bubble),
    .ctrl_i   (head_ctrl_in),
    .data_i   (head_data_in),
    .valid_o  (head_valid),
    .ctrl_o   (head_ctrl),
    .data_o   (head_data)
  );

  assign out_valid = head_valid;
  assign out_ctrl  = head_valid ? head_ctrl : '0;
  assign out_data  = head_valid ? head_data : '0;

  if (SKID == 0) begin : g_single
    assign in_ready     = ~head_valid | out_ready;
    assign head_load    = accept;
    assign head_clear   = flush | (emit & ~accept);
    assign head_bubble  = in_bubble;
    assign head_ctrl_in = in_ctrl;
    assign head_data_in = in_data;
    assign occupancy    = {1'b0, head_valid};
  end else begin : g_skid
    skid_state_e           state_q, state_d;
    logic                  ready_q;
    logic                  skid_load;
    logic                  skid_clear;
    logic                  head_from_skid;
    logic                  skid_valid;
    logic [CTRL_WIDTH-1:0] skid_ctrl;
    logic [DATA_WIDTH-1:0] skid_data;

    pipe_slot #(
      .CTRL_WIDTH (CTRL_WIDTH),
      .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
      .clk      (clk),
      .reset    (reset),
      .clear_i  (skid_clear),
      .load_i   (skid_load),
      .bubble_i (in_bubble),
      .ctrl_i   (in_ctrl),
      .data_i   (in_data),
      .valid_o  (skid_valid),
      .ctrl_o   (skid_ctrl),
      .data_o   (skid_data)
    );

    always_comb begin
      state_d        = state_q;
      head_load      = 1'b0;
      head_clear     = 1'b0;
      skid_load      = 1'b0;
      skid_clear     = 1'b0;
      head_from_skid = 1'b0;
      if (flush) begin
        state_d    = EMPTY;
        head_clear = 1'b1;
        skid_clear = 1'b1;
      end else begin
        unique case (state_q)
          EMPTY: if (accept) begin
            head_load = 1'b1;
            state_d   = ONE;
          end
          ONE: begin
            if (accept && emit) begin
              head_load = 1'b1;
            end else if (accept) begin
              skid_load = 1'b1;
              state_d   = FULL;
            end else if (emit) begin
              head_clear = 1'b1;
              state_d    = EMPTY;
            end
          end
          FULL: if (emit) begin
            // Skid entry already carries its bubble-zeroed ctrl; promote it unchanged.
            head_load      = 1'b1;
            head_from_skid = 1'b1;
            skid_clear     = 1'b1;
            state_d        = ONE;
          end
          default: state_d = EMPTY;
        endcase
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        state_q <= EMPTY;
        ready_q <= 1'b1;
      end else begin
        state_q <= state_d;
        ready_q <= (state_d != FULL);
      end
    end

    assign in_ready     = ready_q;
    assign head_bubble  = head_from_skid ? 1'b0 : in_bubble;
    assign head_ctrl_in = head_from_skid ? skid_ctrl : in_ctrl;
    assign head_data_in = head_from_skid ? skid_data : in_data;
    assign occupancy    = state_q;

    // skid_valid mirrors state_q == FULL; kept for waveform debug.
    logic skid_valid_unused;
    assign skid_valid_unused = skid_valid;
  end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed and random checks of pipe_stage_buf, SKID=0 and SKID=1 side by side on shared inputs.
module tb_pipe_stage_buf;

  logic        clk = 1'b0;
  logic        reset, in_valid, in_bubble, flush, out_ready;
  logic [7:0]  in_ctrl;
  logic [95:0] in_data;

  logic [1:0]  ir, ov;
  logic [7:0]  oc  [2];
  logic [95:0] od  [2];
  logic [1:0]  occ [2];

  int n_cmp = 0;
  int n_err = 0;

  // Reference FIFO model per instance: entry 0 is the head.
  logic [7:0]  mc [2][2];
  logic [95:0] md [2][2];
  int          m_cnt [2];

  always #5 clk = ~clk;

  pipe_stage_buf #(.CTRL_WIDTH(8), .DATA_WIDTH(96), .SKID(0)) u_dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir[0]), .in_bubble(in_bubble),
    .in_ctrl(in_ctrl), .in_data(in_data), .flush(flush), .out_valid(ov[0]),
    .out_ready(out_ready), .out_ctrl(oc[0]), .out_data(od[0]), .occupancy(occ[0])
  );

  pipe_stage_buf #(.CTRL_WIDTH(8), .DATA_WIDTH(96), .SKID(1)) u_dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir[1]), .in_bubble(in_bubble),
    .in_ctrl(in_ctrl), .in_data(in_data), .flush(flush), .out_valid(ov[1]),
    .out_ready(out_ready), .out_ctrl(oc[1]), .out_data(od[1]), .occupancy(occ[1])
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic model_ready(input int k);
    if (k == 0) return (m_cnt[0] == 0) || out_ready;
    return m_cnt[1] != 2;
  endfunction

  // Compare both DUTs against the model at the falling edge.
  task automatic sample();
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("d%0d.out_valid", k), 128'(ov[k]), 128'(m_cnt[k] != 0));
      check($sformatf("d%0d.out_ctrl", k), 128'(oc[k]), (m_cnt[k] != 0) ? 128'(mc[k][0]) : '0);
      check($sformatf("d%0d.out_data", k), 128'(od[k]), (m_cnt[k] != 0) ? 128'(md[k][0]) : '0);
      check($sformatf("d%0d.occupancy", k), 128'(occ[k]), 128'(m_cnt[k]));
      check($sformatf("d%0d.in_ready", k), 128'(ir[k]), 128'(model_ready(k)));
    end
  endtask

  task automatic advance();
    logic acc [2];
    logic emi [2];
    for (int k = 0; k < 2; k++) begin
      acc[k] = in_valid & model_ready(k);
      emi[k] = (m_cnt[k] != 0) & out_ready;
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (reset || flush) begin
        m_cnt[k] = 0;
      end else begin
        if (emi[k]) begin
          mc[k][0] = mc[k][1];
          md[k][0] = md[k][1];
          m_cnt[k]--;
        end
        if (acc[k]) begin
          mc[k][m_cnt[k]] = in_bubble ? 8'h00 : in_ctrl;
          md[k][m_cnt[k]] = in_data;
          m_cnt[k]++;
        end
      end
    end
    #1;
  endtask

  task automatic cyc();
    sample();
    advance();
  endtask

  task automatic drive(input logic v, input logic b, input logic [7:0] c, input logic [95:0] d);
    in_valid  = v;
    in_bubble = b;
    in_ctrl   = c;
    in_data   = d;
  endtask

  initial begin
    m_cnt[0] = 0;
    m_cnt[1] = 0;
    reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
    drive(1'b1, 1'b0, 8'h5A, 96'h5A);

    // 1: reset held two cycles with in_valid high
    advance();
    cyc();
    reset = 1'b0;
    drive(1'b0, 1'b0, 8'h00, '0);
    sample();
    for (int k = 0; k < 2; k++) begin
      check($sformatf("rst.d%0d.out_valid", k), 128'(ov[k]), 128'(0));
      check($sformatf("rst.d%0d.out_ctrl", k), 128'(oc[k]), 128'(0));
      check($sformatf("rst.d%0d.out_data", k), 128'(od[k]), 128'(0));
      check($sformatf("rst.d%0d.occupancy", k), 128'(occ[k]), 128'(0));
      check($sformatf("rst.d%0d.in_ready", k), 128'(ir[k]), 128'(1));
    end
    advance();

    // 2: streaming 0x11..0x18 with out_ready=1
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b0, 8'(32'h11 + i), 96'(32'h100 + i));
      sample();
      if (i > 0) begin
        for (int k = 0; k < 2; k++) begin
          check($sformatf("strm.d%0d.ctrl%0d", k, i), 128'(oc[k]), 128'(32'h10 + i));
          check($sformatf("strm.d%0d.occ%0d", k, i), 128'(occ[k]), 128'(1));
        end
      end
      advance();
    end
    drive(1'b0, 1'b0, 8'h00, '0);
    sample();
    for (int k = 0; k < 2; k++) begin
      check($sformatf("strm.d%0d.last", k), 128'(oc[k]), 128'h18);
      check($sformatf("strm.d%0d.lastocc", k), 128'(occ[k]), 128'(1));
    end
    advance();
    cyc();

    // 3: bubble keeps data, zeroes ctrl
    drive(1'b1, 1'b1, 8'hA5, 96'h1234);
    cyc();
    drive(1'b0, 1'b0, 8'h00, '0);
    sample();
    for (int k = 0; k < 2; k++) begin
      check($sformatf("bub.d%0d.valid", k), 128'(ov[k]), 128'(1));
      check($sformatf("bub.d%0d.ctrl", k), 128'(oc[k]), 128'(0));
      check($sformatf("bub.d%0d.data", k), 128'(od[k]), 128'h1234);
    end
    advance();
    cyc();

    // 4: backpressure into the skid entry, then release
    out_ready = 1'b0;
    drive(1'b1, 1'b0, 8'h0A, 96'hA);
    cyc();
    drive(1'b1, 1'b0, 8'h0B, 96'hB);
    cyc();
    drive(1'b1, 1'b0, 8'h0C, 96'hC);
    sample();
    check("bp.occ", 128'(occ[1]), 128'(2));
    check("bp.in_ready", 128'(ir[1]), 128'(0));
    check("bp.hold", 128'(oc[1]), 128'h0A);
    advance();
    out_ready = 1'b1;
    sample();
    check("bp.outA", 128'(oc[1]), 128'h0A);
    check("bp.noC", 128'(ir[1]), 128'(0));
    advance();
    sample();
    check("bp.outB", 128'(oc[1]), 128'h0B);
    check("bp.readyB", 128'(ir[1]), 128'(1));
    advance();
    drive(1'b0, 1'b0, 8'h00, '0);
    sample();
    check("bp.outC", 128'(oc[1]), 128'h0C);
    check("bp.occC", 128'(occ[1]), 128'(1));
    advance();
    cyc();
    cyc();

    // 5: flush while FULL, with a valid input in the same cycle
    out_ready = 1'b0;
    drive(1'b1, 1'b0, 8'h21, 96'h21);
    cyc();
    drive(1'b1, 1'b0, 8'h22, 96'h22);
    cyc();
    drive(1'b1, 1'b0, 8'h77, 96'h77);
    flush = 1'b1;
    sample();
    check("fl.full", 128'(occ[1]), 128'(2));
    advance();
    flush = 1'b0;
    drive(1'b0, 1'b0, 8'h00, '0);
    sample();
    for (int k = 0; k < 2; k++) begin
      check($sformatf("fl.d%0d.valid", k), 128'(ov[k]), 128'(0));
      check($sformatf("fl.d%0d.occ", k), 128'(occ[k]), 128'(0));
      check($sformatf("fl.d%0d.ready", k), 128'(ir[k]), 128'(1));
      check($sformatf("fl.d%0d.ctrl", k), 128'(oc[k]), 128'(0));
    end
    advance();
    out_ready = 1'b1;
    sample();
    check("fl.gone0", 128'(ov[0]), 128'(0));
    check("fl.gone1", 128'(ov[1]), 128'(0));
    advance();

    // 6: random traffic against the model
    for (int n = 0; n < 10000; n++) begin
      reset     = ($urandom_range(0, 499) == 0);
      flush     = ($urandom_range(0, 63) == 0);
      out_ready = ($urandom_range(0, 9) < 6);
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
            8'($urandom), {$urandom, $urandom, $urandom});
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
